// File: rtl/fft_peak_finder.sv
`default_nettype none
// ============================================================================
// Module   : fft_peak_finder
// Brief    : Consumes an Avalon-ST stream of complex FFT bins and reports,
//            once per frame, the bin index and approximate magnitude of the
//            largest bin inside the positive-frequency search range, together
//            with upstream-error and frame-length flags.
// Optional : FFT_PEAK_NEIGHBOURS_EN - also reports the magnitudes of the bins
//            immediately left and right of the peak (for interpolation).
// Revision : 1.0 - initial release
// ============================================================================
module fft_peak_finder #(
    parameter int DATA_W  = 32,
    parameter int BIN_W   = 14,
    parameter int MIN_BIN = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fft_valid,
    output logic              fft_ready,
    input  logic [1:0]        fft_error,
    input  logic              fft_sop,
    input  logic              fft_eop,
    input  logic [DATA_W-1:0] fft_real,
    input  logic [DATA_W-1:0] fft_imag,
    input  logic [BIN_W-1:0]  fft_pts,
    output logic              peak_valid,
    input  logic              peak_ready,
    output logic [BIN_W-1:0]  peak_bin,
    output logic [DATA_W:0]   peak_mag,
    output logic [DATA_W:0]   peak_mag_left,
    output logic [DATA_W:0]   peak_mag_right,
    output logic [1:0]        peak_error
);

    localparam int MAG_W = DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               fft_ready_q;
    logic               flush_cnt_q, flush_cnt_d;

    logic               w_accept;
    logic               w_beat;
    logic               w_clear;
    logic               w_load;
    logic               w_update;
    logic               w_in_range;
    logic [BIN_W-1:0]   w_beat_bin;
    logic [BIN_W-1:0]   w_beat_pts;
    logic [DATA_W-1:0]  w_abs_re;
    logic [DATA_W-1:0]  w_abs_im;
    logic [DATA_W-1:0]  w_hi;
    logic [DATA_W-1:0]  w_lo;
    logic [MAG_W-1:0]   w_mag;

    // Frame tracking
    logic [BIN_W-1:0]   pts_q;
    logic [BIN_W-1:0]   bin_cnt_q;
    logic               up_err_q;
    logic               len_err_q;

    // Stage 1: absolute values
    logic               s1_valid_q;
    logic [DATA_W-1:0]  s1_abs_re_q;
    logic [DATA_W-1:0]  s1_abs_im_q;
    logic [BIN_W-1:0]   s1_bin_q;
    logic               s1_in_range_q;

    // Stage 2: running maximum
    logic [MAG_W-1:0]   max_mag_q;
    logic [BIN_W-1:0]   max_bin_q;

    // Output registers
    logic [BIN_W-1:0]   peak_bin_q;
    logic [MAG_W-1:0]   peak_mag_q;
    logic [1:0]         peak_error_q;

    assign w_accept   = fft_valid && fft_ready_q;
    assign w_clear    = w_beat && fft_sop;
    assign fft_ready  = fft_ready_q;
    assign peak_valid = (state_q == S_HOLD);
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign peak_error = peak_error_q;

    // A sop beat starts a new frame, so it uses bin 0 and the live fft_pts.
    assign w_beat_bin = fft_sop ? {BIN_W{1'b0}} : bin_cnt_q;
    assign w_beat_pts = fft_sop ? fft_pts : pts_q;
    assign w_in_range = (w_beat_bin >= BIN_W'(MIN_BIN)) && (w_beat_bin < (w_beat_pts >> 1));

    // Negating the most negative value wraps to 2^(DATA_W-1), which is exact as unsigned.
    assign w_abs_re = fft_real[DATA_W-1] ? (DATA_W'(0) - fft_real) : fft_real;
    assign w_abs_im = fft_imag[DATA_W-1] ? (DATA_W'(0) - fft_imag) : fft_imag;

    // Alpha-max-plus-beta-min with alpha = 1, beta = 3/8; at most 1.375 * 2^(DATA_W-1).
    assign w_hi     = (s1_abs_re_q >= s1_abs_im_q) ? s1_abs_re_q : s1_abs_im_q;
    assign w_lo     = (s1_abs_re_q >= s1_abs_im_q) ? s1_abs_im_q : s1_abs_re_q;
    assign w_mag    = {1'b0, w_hi} + MAG_W'(w_lo >> 2) + MAG_W'(w_lo >> 3);
    assign w_update = s1_valid_q && s1_in_range_q && (w_mag > max_mag_q);

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        w_beat      = 1'b0;
        w_load      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept && fft_sop) begin
                    w_beat  = 1'b1;
                    state_d = fft_eop ? S_FLUSH : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    w_beat = 1'b1;
                    if (fft_eop) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                flush_cnt_d = 1'b1;
                if (flush_cnt_q) begin
                    w_load      = 1'b1;
                    flush_cnt_d = 1'b0;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (peak_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; ready is registered so it stays low through reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= 1'b0;
            fft_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            fft_ready_q <= (state_d == S_IDLE) || (state_d == S_COLLECT);
        end
    end

    // Stage 1 capture plus frame length and error bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_abs_re_q   <= '0;
            s1_abs_im_q   <= '0;
            s1_bin_q      <= '0;
            s1_in_range_q <= 1'b0;
            pts_q         <= '0;
            bin_cnt_q     <= '0;
            up_err_q      <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            s1_valid_q <= w_beat;
            if (w_beat) begin
                s1_abs_re_q   <= w_abs_re;
                s1_abs_im_q   <= w_abs_im;
                s1_bin_q      <= w_beat_bin;
                s1_in_range_q <= w_in_range;
                pts_q         <= w_beat_pts;
                bin_cnt_q     <= w_beat_bin + BIN_W'(1);
                up_err_q      <= (fft_sop ? 1'b0 : up_err_q) | (fft_error != 2'b00);
                if (fft_eop) begin
                    len_err_q <= (w_beat_bin != (w_beat_pts - BIN_W'(1)));
                end else if (fft_sop) begin
                    len_err_q <= 1'b0;
                end
            end
        end
    end

    // Stage 2 running maximum; a new sop drops whatever the old frame left in stage 1
    always_ff @(posedge clk) begin
        if (!reset_n || w_clear) begin
            max_mag_q <= '0;
            max_bin_q <= '0;
        end else if (w_update) begin
            max_mag_q <= w_mag;
            max_bin_q <= s1_bin_q;
        end
    end

    // Result registers load at the end of the flush and hold through HOLD
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_error_q <= 2'b00;
        end else if (w_load) begin
            peak_bin_q   <= max_bin_q;
            peak_mag_q   <= max_mag_q;
            peak_error_q <= {len_err_q, up_err_q};
        end
    end

`ifdef FFT_PEAK_NEIGHBOURS_EN
    logic [MAG_W-1:0] prev_mag_q;
    logic [MAG_W-1:0] left_q;
    logic [MAG_W-1:0] right_q;
    logic             need_right_q;
    logic [MAG_W-1:0] peak_left_q;
    logic [MAG_W-1:0] peak_right_q;

    // Track the bins either side of the current maximum as the frame streams by
    always_ff @(posedge clk) begin
        if (!reset_n || w_clear) begin
            prev_mag_q   <= '0;
            left_q       <= '0;
            right_q      <= '0;
            need_right_q <= 1'b0;
        end else if (s1_valid_q) begin
            prev_mag_q <= w_mag;
            if (w_update) begin
                left_q       <= (s1_bin_q == '0) ? '0 : prev_mag_q;
                right_q      <= '0;
                need_right_q <= 1'b1;
            end else if (need_right_q) begin
                right_q      <= w_mag;
                need_right_q <= 1'b0;
            end
        end
    end

    // Neighbour results load alongside the main result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            peak_left_q  <= '0;
            peak_right_q <= '0;
        end else if (w_load) begin
            peak_left_q  <= left_q;
            peak_right_q <= right_q;
        end
    end

    assign peak_mag_left  = peak_left_q;
    assign peak_mag_right = peak_right_q;
`else
    assign peak_mag_left  = '0;
    assign peak_mag_right = '0;
`endif

endmodule
`default_nettype wire
